// File: rtl/branch_next_pc_if.sv
`default_nettype none
// ============================================================================
// Module  : branch_next_pc_if
// Brief   : Fetch, ID-resolution and fault signals for branch_next_pc.
// Revision: 1.0
// ============================================================================
interface branch_next_pc_if;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        stall;
  logic        id_valid;
  logic [31:0] id_pc;
  logic        jal;
  logic        branch;
  logic [2:0]  funct3;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm_in;
  logic        flush_id;
  logic        misalign_fault;
  logic [31:0] fault_pc;
  logic        fault_clear;

  modport master (
    input  fetch_ready, stall, id_valid, id_pc, jal, branch, funct3,
           rs1_val, rs2_val, imm_in, fault_clear,
    output fetch_valid, fetch_pc, flush_id, misalign_fault, fault_pc
  );

  modport slave (
    output fetch_ready, stall, id_valid, id_pc, jal, branch, funct3,
           rs1_val, rs2_val, imm_in, fault_clear,
    input  fetch_valid, fetch_pc, flush_id, misalign_fault, fault_pc
  );
endinterface
`default_nettype wire

// File: rtl/branch_next_pc.sv
`default_nettype none
// ============================================================================
// Module  : branch_next_pc
// Brief   : Fetch-PC sequencer with ID-stage branch/JAL resolution,
//           backpressured redirect and misaligned-target trap.
// Revision: 1.0
// ============================================================================
module branch_next_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  branch_next_pc_if.master bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PEND  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] fetch_pc_q;
  logic [31:0] redirect_pc_q;
  logic [31:0] fault_pc_q;

  logic        w_cond;
  logic        w_take;
  logic [31:0] w_target;
  logic        w_misaligned;
  logic        w_fetch_valid;

  always_comb begin
    w_cond = 1'b0;
    unique case (bus.funct3)
      3'b000:  w_cond = (bus.rs1_val == bus.rs2_val);
      3'b001:  w_cond = (bus.rs1_val != bus.rs2_val);
      3'b100:  w_cond = ($signed(bus.rs1_val) <  $signed(bus.rs2_val));
      3'b101:  w_cond = ($signed(bus.rs1_val) >= $signed(bus.rs2_val));
      3'b110:  w_cond = (bus.rs1_val <  bus.rs2_val);
      3'b111:  w_cond = (bus.rs1_val >= bus.rs2_val);
      default: w_cond = 1'b0;
    endcase
  end

  assign w_target     = bus.id_pc + bus.imm_in;
  assign w_misaligned = (w_target[1:0] != 2'b00);
  assign w_take       = (state_q == ST_RUN) && bus.id_valid && !bus.stall &&
                        (bus.jal || (bus.branch && w_cond));

  always_comb begin
    w_fetch_valid = 1'b0;
    case (state_q)
      ST_RUN:  w_fetch_valid = !bus.stall;
      ST_PEND: w_fetch_valid = 1'b1;  // in-flight request must complete
      default: w_fetch_valid = 1'b0;
    endcase
  end

  assign bus.fetch_valid    = w_fetch_valid;
  assign bus.flush_id       = (state_q == ST_RUN) ? w_take : 1'b1;
  assign bus.misalign_fault = (state_q == ST_FAULT);
  assign bus.fetch_pc       = fetch_pc_q;
  assign bus.fault_pc       = fault_pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      fetch_pc_q    <= RESET_PC;
      redirect_pc_q <= 32'd0;
      fault_pc_q    <= 32'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (w_take) begin
            if (w_misaligned) begin
              fault_pc_q <= bus.id_pc;
              state_q    <= ST_FAULT;
            end else if (bus.fetch_ready) begin
              fetch_pc_q <= w_target;
            end else begin
              redirect_pc_q <= w_target;
              state_q       <= ST_PEND;
            end
          end else if (w_fetch_valid && bus.fetch_ready) begin
            fetch_pc_q <= fetch_pc_q + 32'd4;
          end
        end
        ST_PEND: begin
          if (bus.fetch_ready) begin
            fetch_pc_q <= redirect_pc_q;
            state_q    <= ST_RUN;
          end
        end
        ST_FAULT: begin
          if (bus.fault_clear) begin
            fetch_pc_q <= fault_pc_q + 32'd4;
            state_q    <= ST_RUN;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_next_pc.sv
`default_nettype none
// ============================================================================
// Module  : tb_branch_next_pc
// Brief   : Directed self-checking bench for branch_next_pc.
// Revision: 1.0
// ============================================================================
module tb_branch_next_pc;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  branch_next_pc_if bus ();

  branch_next_pc #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_id();
    bus.id_valid = 1'b0;
    bus.jal      = 1'b0;
    bus.branch   = 1'b0;
  endtask

  task automatic id_instr(input logic j, input logic b, input logic [2:0] f3,
                          input logic [31:0] pc, input logic [31:0] imm,
                          input logic [31:0] a, input logic [31:0] c);
    bus.id_valid = 1'b1;
    bus.jal      = j;
    bus.branch   = b;
    bus.funct3   = f3;
    bus.id_pc    = pc;
    bus.imm_in   = imm;
    bus.rs1_val  = a;
    bus.rs2_val  = c;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.fetch_ready = 1'b0;
    bus.stall       = 1'b0;
    bus.fault_clear = 1'b0;
    bus.funct3      = 3'b000;
    bus.id_pc       = 32'd0;
    bus.imm_in      = 32'd0;
    bus.rs1_val     = 32'd0;
    bus.rs2_val     = 32'd0;
    idle_id();
    step();
    step();

    // Reset state
    chk("rst_fetch_pc",    bus.fetch_pc, 32'h0);
    chk("rst_fault_pc",    bus.fault_pc, 32'h0);
    chk("rst_misalign",    {31'd0, bus.misalign_fault}, 32'd0);
    chk("rst_flush",       {31'd0, bus.flush_id}, 32'd0);
    chk("rst_fetch_valid", {31'd0, bus.fetch_valid}, 32'd1);

    // Sequential fetch
    rst_n = 1'b1;
    bus.fetch_ready = 1'b1;
    #1 chk("seq_pc0", bus.fetch_pc, 32'h0);
    step();
    chk("seq_pc4", bus.fetch_pc, 32'h4);
    chk("seq_flush", {31'd0, bus.flush_id}, 32'd0);
    step();
    chk("seq_pc8", bus.fetch_pc, 32'h8);
    chk("seq_valid", {31'd0, bus.fetch_valid}, 32'd1);

    // Taken BEQ, no backpressure
    id_instr(1'b0, 1'b1, 3'b000, 32'h100, 32'hFFFF_FFF0, 32'd5, 32'd5);
    #1 chk("beq_flush", {31'd0, bus.flush_id}, 32'd1);
    step();
    chk("beq_target", bus.fetch_pc, 32'hF0);
    idle_id();
    #1 chk("beq_flush_end", {31'd0, bus.flush_id}, 32'd0);

    // Condition decode, checked through the combinational flush
    id_instr(1'b0, 1'b1, 3'b001, 32'h100, 32'h10, 32'd5, 32'd5);
    #1 chk("bne_equal", {31'd0, bus.flush_id}, 32'd0);
    bus.rs1_val = 32'hFFFF_FFFF;
    bus.rs2_val = 32'd1;
    bus.funct3 = 3'b100;
    #1 chk("blt_signed", {31'd0, bus.flush_id}, 32'd1);
    bus.funct3 = 3'b101;
    #1 chk("bge_signed", {31'd0, bus.flush_id}, 32'd0);
    bus.funct3 = 3'b110;
    #1 chk("bltu", {31'd0, bus.flush_id}, 32'd0);
    bus.funct3 = 3'b111;
    #1 chk("bgeu", {31'd0, bus.flush_id}, 32'd1);
    bus.funct3 = 3'b010;
    #1 chk("f3_010", {31'd0, bus.flush_id}, 32'd0);
    idle_id();
    step();
    chk("cond_seq_pc", bus.fetch_pc, 32'hF4);

    // JAL to 0x20C with memory ready
    id_instr(1'b1, 1'b0, 3'b010, 32'h200, 32'hC, 32'd0, 32'd0);
    step();
    chk("jal_pc", bus.fetch_pc, 32'h20C);

    // Redirect under backpressure; stall ignored while pending
    bus.fetch_ready = 1'b0;
    bus.imm_in = 32'h40;
    #1 chk("bp_flush0", {31'd0, bus.flush_id}, 32'd1);
    step();
    idle_id();
    chk("bp_hold1", bus.fetch_pc, 32'h20C);
    chk("bp_flush1", {31'd0, bus.flush_id}, 32'd1);
    step();
    bus.stall = 1'b1;
    #1 chk("bp_hold2", bus.fetch_pc, 32'h20C);
    chk("bp_valid_stall", {31'd0, bus.fetch_valid}, 32'd1);
    chk("bp_flush2", {31'd0, bus.flush_id}, 32'd1);
    step();
    bus.stall = 1'b0;
    bus.fetch_ready = 1'b1;
    #1 chk("bp_flush_hs", {31'd0, bus.flush_id}, 32'd1);
    chk("bp_hold_hs", bus.fetch_pc, 32'h20C);
    step();
    chk("bp_target", bus.fetch_pc, 32'h240);
    chk("bp_flush_end", {31'd0, bus.flush_id}, 32'd0);

    // Misaligned target trap
    id_instr(1'b0, 1'b1, 3'b000, 32'h300, 32'h6, 32'd7, 32'd7);
    #1 chk("mis_flush", {31'd0, bus.flush_id}, 32'd1);
    step();
    idle_id();
    chk("mis_fault", {31'd0, bus.misalign_fault}, 32'd1);
    chk("mis_fault_pc", bus.fault_pc, 32'h300);
    chk("mis_valid", {31'd0, bus.fetch_valid}, 32'd0);
    step();
    chk("mis_hold_pc", bus.fetch_pc, 32'h240);
    chk("mis_flush_flt", {31'd0, bus.flush_id}, 32'd1);
    bus.fault_clear = 1'b1;
    step();
    bus.fault_clear = 1'b0;
    chk("mis_resume_pc", bus.fetch_pc, 32'h304);
    chk("mis_cleared", {31'd0, bus.misalign_fault}, 32'd0);
    chk("mis_valid_run", {31'd0, bus.fetch_valid}, 32'd1);

    // Stall together with a taken branch
    bus.stall = 1'b1;
    id_instr(1'b0, 1'b1, 3'b000, 32'h100, 32'h10, 32'd1, 32'd1);
    #1 chk("stall_flush", {31'd0, bus.flush_id}, 32'd0);
    chk("stall_valid", {31'd0, bus.fetch_valid}, 32'd0);
    step();
    chk("stall_frozen", bus.fetch_pc, 32'h304);
    idle_id();
    bus.stall = 1'b0;

    // Sequential increment wraps to zero
    id_instr(1'b1, 1'b0, 3'b000, 32'h0, 32'hFFFF_FFFC, 32'd0, 32'd0);
    step();
    idle_id();
    chk("wrap_top", bus.fetch_pc, 32'hFFFF_FFFC);
    step();
    chk("wrap_zero", bus.fetch_pc, 32'h0);

    // Reset while pending
    bus.fetch_ready = 1'b0;
    id_instr(1'b1, 1'b0, 3'b000, 32'h400, 32'h20, 32'd0, 32'd0);
    step();
    idle_id();
    chk("pend_flush", {31'd0, bus.flush_id}, 32'd1);
    rst_n = 1'b0;
    #1 chk("pend_rst_pc", bus.fetch_pc, 32'h0);
    chk("pend_rst_flush", {31'd0, bus.flush_id}, 32'd0);
    step();
    rst_n = 1'b1;
    bus.fetch_ready = 1'b1;
    step();
    chk("pend_rst_run", bus.fetch_pc, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
